regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and grant encoding for the register-file writeback arbiter.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 32;

  // Identifies which writeback source won the most recent transfer.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_LSU = 1'b1
  } grant_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: bit 0 = ALU, bit 1 = LSU.
// Grants are combinational from the requests and the last-grant register.
// Every grant is a transfer, because a requester's valid is the request itself.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  grant_t last_q;
  grant_t last_d;

  // One-hot grant; while reset is asserted nothing is granted.
  always_comb begin
    gnt_o = '0;
    if (!rst_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_q == GNT_LSU) ? 2'b01 : 2'b10;
        default: gnt_o = '0;
      endcase
    end
  end

  // The last-grant state advances only when a transfer happens.
  always_comb begin
    last_d = last_q;
    if (gnt_o[0]) begin
      last_d = GNT_ALU;
    end else if (gnt_o[1]) begin
      last_d = GNT_LSU;
    end
  end

  // Reset to LSU so the ALU wins the first conflict.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= GNT_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file: merges ALU and LSU writebacks
// into one registered write port and tracks pending writes per register.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned n       = DATA_W,
  parameter int unsigned address = ADDR_W,
  parameter int unsigned m       = NREG
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alu_valid_i,
  input  logic [address-1:0] alu_addr_i,
  input  logic [n-1:0]       alu_data_i,
  output logic               alu_ready_o,
  input  logic               lsu_valid_i,
  input  logic [address-1:0] lsu_addr_i,
  input  logic [n-1:0]       lsu_data_i,
  output logic               lsu_ready_o,
  input  logic               issue_valid_i,
  input  logic [address-1:0] issue_addr_i,
  input  logic [address-1:0] rs1_addr_i,
  input  logic [address-1:0] rs2_addr_i,
  output logic               rs1_busy_o,
  output logic               rs2_busy_o,
  output logic               rd_wr_o,
  output logic [address-1:0] rd_addr_o,
  output logic [n-1:0]       rd_data_o
);

  logic [1:0]         gnt;
  logic               xfer;
  logic [address-1:0] win_addr;
  logic [n-1:0]       win_data;

  logic               rd_wr_q,   rd_wr_d;
  logic [address-1:0] rd_addr_q, rd_addr_d;
  logic [n-1:0]       rd_data_q, rd_data_d;
  logic [m-1:0]       flags_q,   flags_d;

  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({lsu_valid_i, alu_valid_i}),
    .gnt_o (gnt)
  );

  assign alu_ready_o = gnt[0];
  assign lsu_ready_o = gnt[1];
  assign xfer        = |gnt;

  // Select the winning requester's address and data.
  always_comb begin
    win_addr = alu_addr_i;
    win_data = alu_data_i;
    if (gnt[1]) begin
      win_addr = lsu_addr_i;
      win_data = lsu_data_i;
    end
  end

  // Write port next state; writes to register 0 are accepted but suppressed.
  always_comb begin
    rd_wr_d   = xfer && (win_addr != '0);
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (xfer) begin
      rd_addr_d = win_addr;
      rd_data_d = win_data;
    end
  end

  // Scoreboard next state: clear on completed write, then set on issue so set wins.
  always_comb begin
    flags_d = flags_q;
    if (rd_wr_q) begin
      flags_d[rd_addr_q] = 1'b0;
    end
    if (issue_valid_i && (issue_addr_i != '0)) begin
      flags_d[issue_addr_i] = 1'b1;
    end
    flags_d[0] = 1'b0;
  end

  // Registered write port and scoreboard flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_wr_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      flags_q   <= '0;
    end else begin
      rd_wr_q   <= rd_wr_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      flags_q   <= flags_d;
    end
  end

  assign rd_wr_o    = rd_wr_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_data_o  = rd_data_q;
  assign rs1_busy_o = flags_q[rs1_addr_i];
  assign rs2_busy_o = flags_q[rs2_addr_i];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_addr_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_addr_i;
  logic [31:0] lsu_data_i;
  logic        lsu_ready_o;
  logic        issue_valid_i;
  logic [4:0]  issue_addr_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        rs1_busy_o;
  logic        rs2_busy_o;
  logic        rd_wr_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.n(32), .address(5), .m(32)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .alu_valid_i   (alu_valid_i),
    .alu_addr_i    (alu_addr_i),
    .alu_data_i    (alu_data_i),
    .alu_ready_o   (alu_ready_o),
    .lsu_valid_i   (lsu_valid_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_data_i    (lsu_data_i),
    .lsu_ready_o   (lsu_ready_o),
    .issue_valid_i (issue_valid_i),
    .issue_addr_i  (issue_addr_i),
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_busy_o    (rs1_busy_o),
    .rs2_busy_o    (rs2_busy_o),
    .rd_wr_o       (rd_wr_o),
    .rd_addr_o     (rd_addr_o),
    .rd_data_o     (rd_data_o)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    alu_valid_i = 1'b1; alu_addr_i = 5'd3; alu_data_i = 32'h1;
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd4; lsu_data_i = 32'h2;
    issue_valid_i = 1'b0; issue_addr_i = '0;
    rs1_addr_i = 5'd3; rs2_addr_i = 5'd4;
    #2;
    n_checks++;
    if ({alu_ready_o, lsu_ready_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=00", {alu_ready_o, lsu_ready_o});
    end
    step(); step();
    n_checks++;
    if ({rd_wr_o, rd_addr_o, rd_data_o} !== {1'b0, 5'd0, 32'd0}) begin
      n_fail++; $display("FAIL reset_port got wr=%b addr=%0d data=%h exp 0/0/0", rd_wr_o, rd_addr_o, rd_data_o);
    end
    n_checks++;
    if ({rs1_busy_o, rs2_busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL reset_busy got=%b exp=00", {rs1_busy_o, rs2_busy_o});
    end
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_alu_only();
    alu_valid_i = 1'b1; alu_addr_i = 5'd5; alu_data_i = 32'hDEADBEEF;
    #1;
    n_checks++;
    if ({alu_ready_o, lsu_ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL alu_only_ready got alu/lsu=%b exp=10", {alu_ready_o, lsu_ready_o});
    end
    step();
    alu_valid_i = 1'b0;
    #1;
    n_checks++;
    if ({rd_wr_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL alu_only_write got wr=%b addr=%0d data=%h exp 1/5/deadbeef", rd_wr_o, rd_addr_o, rd_data_o);
    end
    step();
    n_checks++;
    if (rd_wr_o !== 1'b0) begin
      n_fail++; $display("FAIL alu_only_idle got wr=%b exp=0", rd_wr_o);
    end
  endtask

  task automatic test_zero_addr();
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd0; lsu_data_i = 32'h1234;
    issue_valid_i = 1'b1; issue_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
    #1;
    n_checks++;
    if ({alu_ready_o, lsu_ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL zero_ready got alu/lsu=%b exp=01", {alu_ready_o, lsu_ready_o});
    end
    step();
    lsu_valid_i = 1'b0; issue_valid_i = 1'b0;
    #1;
    n_checks++;
    if (rd_wr_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_wr got=%b exp=0", rd_wr_o);
    end
    n_checks++;
    if (rs2_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL zero_busy got=%b exp=0", rs2_busy_o);
    end
    step();
  endtask

  // Last grant is LSU after the zero-address test, so ALU leads.
  task automatic test_back_to_back();
    logic       exp_alu;
    logic [4:0] exp_addr;
    logic [31:0] exp_data;
    alu_valid_i = 1'b1; alu_addr_i = 5'd1; alu_data_i = 32'h0000_0011;
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd2; lsu_data_i = 32'h0000_0022;
    for (int i = 0; i < 4; i++) begin
      exp_alu  = (i % 2 == 0);
      exp_addr = exp_alu ? 5'd1 : 5'd2;
      exp_data = exp_alu ? 32'h11 : 32'h22;
      #1;
      n_checks++;
      if ({alu_ready_o, lsu_ready_o} !== {exp_alu, ~exp_alu}) begin
        n_fail++; $display("FAIL rr_grant[%0d] got alu/lsu=%b exp=%b", i, {alu_ready_o, lsu_ready_o}, {exp_alu, ~exp_alu});
      end
      step();
      n_checks++;
      if ({rd_wr_o, rd_addr_o, rd_data_o} !== {1'b1, exp_addr, exp_data}) begin
        n_fail++; $display("FAIL rr_write[%0d] got wr=%b addr=%0d data=%h exp 1/%0d/%h", i, rd_wr_o, rd_addr_o, rd_data_o, exp_addr, exp_data);
      end
    end
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    step();
    n_checks++;
    if (rd_wr_o !== 1'b0) begin
      n_fail++; $display("FAIL rr_idle got wr=%b exp=0", rd_wr_o);
    end
  endtask

  task automatic test_scoreboard();
    rs1_addr_i = 5'd7;
    issue_valid_i = 1'b1; issue_addr_i = 5'd7;
    step();
    issue_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rs1_busy_o !== 1'b1) begin
        n_fail++; $display("FAIL sb_pending[%0d] got=%b exp=1", i, rs1_busy_o);
      end
      step();
    end
    alu_valid_i = 1'b1; alu_addr_i = 5'd7; alu_data_i = 32'hCAFE0007;
    step();
    alu_valid_i = 1'b0;
    n_checks++;
    if ({rd_wr_o, rd_addr_o, rs1_busy_o} !== {1'b1, 5'd7, 1'b1}) begin
      n_fail++; $display("FAIL sb_write_cycle got wr=%b addr=%0d busy=%b exp 1/7/1", rd_wr_o, rd_addr_o, rs1_busy_o);
    end
    step();
    n_checks++;
    if (rs1_busy_o !== 1'b0) begin
      n_fail++; $display("FAIL sb_cleared got=%b exp=0", rs1_busy_o);
    end
  endtask

  task automatic test_set_wins();
    rs1_addr_i = 5'd9;
    issue_valid_i = 1'b1; issue_addr_i = 5'd9;
    alu_valid_i = 1'b1; alu_addr_i = 5'd9; alu_data_i = 32'h99;
    step();
    alu_valid_i = 1'b0;
    n_checks++;
    if ({rd_wr_o, rd_addr_o, rs1_busy_o} !== {1'b1, 5'd9, 1'b1}) begin
      n_fail++; $display("FAIL setwin_pre got wr=%b addr=%0d busy=%b exp 1/9/1", rd_wr_o, rd_addr_o, rs1_busy_o);
    end
    step();
    issue_valid_i = 1'b0;
    n_checks++;
    if (rs1_busy_o !== 1'b1) begin
      n_fail++; $display("FAIL setwin_edge got=%b exp=1", rs1_busy_o);
    end
    step();
    n_checks++;
    if (rs1_busy_o !== 1'b1) begin
      n_fail++; $display("FAIL setwin_hold got=%b exp=1", rs1_busy_o);
    end
  endtask

  // Last grant is ALU here, so without reset the LSU would win.
  task automatic test_reset_mid();
    rs2_addr_i = 5'd3;
    issue_valid_i = 1'b1; issue_addr_i = 5'd3;
    step();
    issue_valid_i = 1'b0;
    alu_valid_i = 1'b1; alu_addr_i = 5'd4; alu_data_i = 32'h44;
    lsu_valid_i = 1'b1; lsu_addr_i = 5'd6; lsu_data_i = 32'h66;
    #1;
    n_checks++;
    if ({alu_ready_o, lsu_ready_o, rs2_busy_o} !== 3'b011) begin
      n_fail++; $display("FAIL rstmid_pre got alu/lsu/busy=%b exp=011", {alu_ready_o, lsu_ready_o, rs2_busy_o});
    end
    rst_i = 1'b1;
    #1;
    n_checks++;
    if ({alu_ready_o, lsu_ready_o, rd_wr_o, rs1_busy_o, rs2_busy_o} !== 5'b00000) begin
      n_fail++; $display("FAIL rstmid_during got rdy/wr/busy=%b exp=00000", {alu_ready_o, lsu_ready_o, rd_wr_o, rs1_busy_o, rs2_busy_o});
    end
    step();
    n_checks++;
    if ({rd_wr_o, rs2_busy_o} !== 2'b00) begin
      n_fail++; $display("FAIL rstmid_edge got wr/busy=%b exp=00", {rd_wr_o, rs2_busy_o});
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({alu_ready_o, lsu_ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL rstmid_first got alu/lsu=%b exp=10", {alu_ready_o, lsu_ready_o});
    end
    step();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0;
    n_checks++;
    if ({rd_wr_o, rd_addr_o, rd_data_o} !== {1'b1, 5'd4, 32'h44}) begin
      n_fail++; $display("FAIL rstmid_write got wr=%b addr=%0d data=%h exp 1/4/44", rd_wr_o, rd_addr_o, rd_data_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_zero_addr();
    test_back_to_back();
    test_scoreboard();
    test_set_wins();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
